// File: rtl/macrocell_cfg_loader.sv
// Serial fuse-word loader for one macrocell: shifts a parity-protected word into a shadow
// register, commits it to the active select bus, and shifts the active word back out for verify.
module macrocell_cfg_loader #(
    parameter int               CFG_W     = 21,
    parameter logic [CFG_W-1:0] RESET_CFG = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_start,
    input  logic             cfg_bit_v,
    input  logic             cfg_bit_valid,
    output logic             cfg_bit_ready,
    input  logic             commit_v,
    input  logic             readback_start,
    output logic             rb_bit_v,
    output logic             rb_bit_valid,
    input  logic             rb_bit_ready,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CFG_W-1:0] mc_cfg_v
);

    // state | meaning
    // IDLE  | no transfer; waits for load_start or readback_start
    // SHIFT | accepting fuse bits 0..CFG_W-1 into the shadow
    // CHECK | accepting the even-parity bit for the shadow
    // ARMED | shadow verified; waits for commit_v
    // READ  | shifting the active word out, then its parity bit

    localparam int                 CNT_W    = $clog2(CFG_W + 1);
    localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(CFG_W - 1);
    localparam logic [CNT_W-1:0]   PAR_CNT  = CNT_W'(CFG_W);

    typedef enum logic [2:0] {IDLE, SHIFT, CHECK, ARMED, READ} state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [CFG_W-1:0] shadow;
    logic [CFG_W-1:0] rd_sr;

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            count         <= '0;
            shadow        <= '0;
            rd_sr         <= '0;
            mc_cfg_v      <= RESET_CFG;
            cfg_bit_ready <= 1'b0;
            rb_bit_valid  <= 1'b0;
            rb_bit_v      <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            done <= 1'b0;
            // load_start restarts from any state except an in-flight readback
            if (load_start && state != READ) begin
                state         <= SHIFT;
                count         <= '0;
                shadow        <= '0;
                err           <= 1'b0;
                cfg_bit_ready <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (readback_start) begin
                            state        <= READ;
                            rd_sr        <= mc_cfg_v;
                            count        <= '0;
                            rb_bit_valid <= 1'b1;
                            rb_bit_v     <= mc_cfg_v[0];
                        end
                    end
                    SHIFT: begin
                        if (cfg_bit_valid) begin
                            shadow[count] <= cfg_bit_v;
                            count         <= count + 1'b1;
                            if (count == LAST_BIT) begin
                                state <= CHECK;
                            end
                        end
                    end
                    CHECK: begin
                        if (cfg_bit_valid) begin
                            cfg_bit_ready <= 1'b0;
                            if (^{shadow, cfg_bit_v}) begin
                                err   <= 1'b1;
                                state <= IDLE;
                            end else begin
                                state <= ARMED;
                            end
                        end
                    end
                    ARMED: begin
                        if (commit_v) begin
                            mc_cfg_v <= shadow;
                            done     <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                    READ: begin
                        if (rb_bit_ready) begin
                            if (count == PAR_CNT) begin
                                state        <= IDLE;
                                done         <= 1'b1;
                                rb_bit_valid <= 1'b0;
                                rb_bit_v     <= 1'b0;
                                count        <= '0;
                            end else begin
                                rd_sr    <= rd_sr >> 1;
                                count    <= count + 1'b1;
                                // after the last data bit comes the even-parity bit of the active word
                                rb_bit_v <= (count == LAST_BIT) ? ^mc_cfg_v : rd_sr[1];
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_macrocell_cfg_loader.sv
// Self-checking bench for macrocell_cfg_loader: directed loads, commits and readbacks
// with queued expectations compared by negedge monitors.
module tb_macrocell_cfg_loader;

    localparam int W = 21;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_start;
    logic         cfg_bit_v;
    logic         cfg_bit_valid;
    logic         cfg_bit_ready;
    logic         commit_v;
    logic         readback_start;
    logic         rb_bit_v;
    logic         rb_bit_valid;
    logic         rb_bit_ready;
    logic         busy;
    logic         done;
    logic         err;
    logic [W-1:0] mc_cfg_v;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_done_q[$];
    logic        exp_rb_q[$];

    macrocell_cfg_loader #(.CFG_W(W), .RESET_CFG('0)) dut (
        .clk            (clk),
        .rst            (rst),
        .load_start     (load_start),
        .cfg_bit_v      (cfg_bit_v),
        .cfg_bit_valid  (cfg_bit_valid),
        .cfg_bit_ready  (cfg_bit_ready),
        .commit_v       (commit_v),
        .readback_start (readback_start),
        .rb_bit_v       (rb_bit_v),
        .rb_bit_valid   (rb_bit_valid),
        .rb_bit_ready   (rb_bit_ready),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .mc_cfg_v       (mc_cfg_v)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // done monitor: each done pulse consumes one expected active word
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_done_q.size() == 0) begin
                chk("done_unexpected", 32'd1, 32'd0);
            end else begin
                chk("done_early", 32'(exp_rb_q.size()), 32'd0);
                chk("done_cfg", 32'(mc_cfg_v), exp_done_q.pop_front());
            end
        end
    end

    // readback monitor: bit must match the head of the queue while valid, popped on each beat
    always @(negedge clk) begin
        if (!rst && rb_bit_valid) begin
            if (exp_rb_q.size() == 0) begin
                chk("rb_unexpected", 32'd1, 32'd0);
            end else begin
                chk("rb_bit", 32'(rb_bit_v), 32'(exp_rb_q[0]));
                if (rb_bit_ready) void'(exp_rb_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        int n = 0;
        cfg_bit_valid = 1'b1;
        cfg_bit_v     = b;
        while (!cfg_bit_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("ready_timeout", 32'd0, 32'd1);
        tick();
        cfg_bit_valid = 1'b0;
        cfg_bit_v     = 1'b0;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic load(input logic [31:0] word, input logic par);
        start_load();
        for (int i = 0; i < W; i++) send_bit(word[i]);
        send_bit(par);
    endtask

    task automatic commit(input logic [31:0] word);
        exp_done_q.push_back(word);
        commit_v = 1'b1;
        tick();
        commit_v = 1'b0;
        tick();
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    task automatic do_readback(input logic [31:0] word, input logic stall);
        int n = 0;
        logic [W-1:0] w;
        w = word[W-1:0];
        for (int i = 0; i < W; i++) exp_rb_q.push_back(w[i]);
        exp_rb_q.push_back(^w);
        exp_done_q.push_back(word);
        readback_start = 1'b1;
        tick();
        readback_start = 1'b0;
        while (exp_rb_q.size() != 0 && n < 200) begin
            rb_bit_ready = stall ? ~rb_bit_ready : 1'b1;
            tick();
            n++;
        end
        if (n >= 200) chk("rb_timeout", 32'd0, 32'd1);
        rb_bit_ready = 1'b0;
        tick();
        tick();
        chk("rb_done_seen", 32'(exp_done_q.size()), 32'd0);
        chk("rb_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        load_start     = 1'b0;
        cfg_bit_v      = 1'b0;
        cfg_bit_valid  = 1'b0;
        commit_v       = 1'b0;
        readback_start = 1'b0;
        rb_bit_ready   = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_cfg", 32'(mc_cfg_v), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ready", 32'(cfg_bit_ready), 32'd0);
        chk("rst_rb_valid", 32'(rb_bit_valid), 32'd0);
        chk("rst_rb_bit", 32'(rb_bit_v), 32'd0);
        rst = 1'b0;
        tick();

        // good load, commit, then readback with mixed bits and no stalls
        load(32'h0A5A5, 1'b0);
        commit(32'h0A5A5);
        do_readback(32'h0A5A5, 1'b0);

        // bad parity: error, back to idle, active word untouched
        load(32'h0A5A5, 1'b1);
        @(negedge clk);
        chk("par_err", 32'(err), 32'd1);
        chk("par_idle", 32'(busy), 32'd0);
        chk("par_cfg_kept", 32'(mc_cfg_v), 32'h0A5A5);
        tick();
        start_load();
        @(negedge clk);
        chk("err_cleared", 32'(err), 32'd0);
        chk("reload_busy", 32'(busy), 32'd1);
        tick();

        // abandon a load after 10 bits, restart with 0x00003
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        chk("midload_cfg", 32'(mc_cfg_v), 32'h0A5A5);
        load(32'h00003, 1'b0);
        commit(32'h00003);

        // all ones, then readback with the consumer stalling every other cycle
        load(32'h1FFFFF, 1'b1);
        commit(32'h1FFFFF);
        do_readback(32'h1FFFFF, 1'b1);

        // reset while armed discards the shadow and the later commit
        load(32'h00005, 1'b0);
        @(negedge clk);
        chk("armed_busy", 32'(busy), 32'd1);
        chk("armed_ready", 32'(cfg_bit_ready), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        commit_v = 1'b1;
        tick();
        commit_v = 1'b0;
        tick();
        @(negedge clk);
        chk("rst_armed_cfg", 32'(mc_cfg_v), 32'd0);
        chk("rst_armed_busy", 32'(busy), 32'd0);
        tick();

        // simultaneous load_start and readback_start: load wins
        load_start     = 1'b1;
        readback_start = 1'b1;
        tick();
        load_start     = 1'b0;
        readback_start = 1'b0;
        @(negedge clk);
        chk("both_ready", 32'(cfg_bit_ready), 32'd1);
        chk("both_busy", 32'(busy), 32'd1);
        chk("both_rb_valid", 32'(rb_bit_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("both_rb_valid2", 32'(rb_bit_valid), 32'd0);

        chk("rb_queue_empty", 32'(exp_rb_q.size()), 32'd0);
        chk("done_queue_empty", 32'(exp_done_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
